// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle between a requester and the sequential multiplier.
// Latency: none, this is wiring only.
// Backpressure: none; the requester must watch busy, starts while busy are dropped.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Requester side: issues operands, watches status and result.
    modport master (
        output start,
        output m,
        output q,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  m,
        input  q,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock.
// Latency: start edge + WIDTH iterations, then a one-cycle done pulse (fewer with MULT_EARLY_TERM_EN).
// Backpressure: none; start is sampled only in IDLE, requests while busy are dropped, no queueing.
// Optional macro MULT_EARLY_TERM_EN: stop iterating once no set multiplier bits remain.
module mult_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    mult_seq_ctrl_if.slave    bus
);

    localparam int              PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [PW-1:0]      mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [PW-1:0]      acc_q,     acc_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]      product_q, product_d;

    logic [PW-1:0]      sum_w;
    logic [WIDTH-1:0]   mplier_shift_w;
    logic               last_iter_w;

    // Datapath for one iteration: conditional add and the exit test.
    always_comb begin
        sum_w          = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift_w = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
        last_iter_w    = (cnt_q == LAST_CNT) || (mplier_shift_w == '0);
`else
        last_iter_w    = (cnt_q == LAST_CNT);
`endif
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: capture in IDLE, iterate in CALC, single-cycle DONE.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.m};
                    mplier_d = bus.q;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef MULT_EARLY_TERM_EN
                    // Nothing to accumulate: skip straight to the result.
                    if (bus.q == '0) begin
                        product_d = '0;
                        state_d   = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d    = sum_w;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift_w;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter_w) begin
                    product_d = sum_w;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decoded straight from state so busy/done can never disagree with it.
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural reference model.
// Latency: expected done edge derived from the multiplier operand.
// Backpressure: exercises starts issued while busy.
module tb_mult_seq_ctrl;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;
    int n_req;
    int done_cnt;
    int unstable;
    logic [2*WIDTH-1:0] prev_product;
    logic prev_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and catch product changes outside a done cycle.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (!rst && !prev_rst && !bus.done && (bus.product !== prev_product)) unstable++;
        prev_product = bus.product;
        prev_rst     = rst;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Number of clock edges after the start edge until done is visible.
    function automatic int ref_lat(input logic [WIDTH-1:0] qv);
`ifdef MULT_EARLY_TERM_EN
        int hi;
        hi = -1;
        for (int b = 0; b < WIDTH; b++) if (qv[b]) hi = b;
        return hi + 1;
`else
        return WIDTH;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [WIDTH-1:0] mi, input logic [WIDTH-1:0] qi);
        int edges;
        logic [2*WIDTH-1:0] exp_p;
        exp_p = (2*WIDTH)'(mi) * (2*WIDTH)'(qi);
        bus.start = 1'b1;
        bus.m     = mi;
        bus.q     = qi;
        n_req++;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.m     = WIDTH'($urandom);
        bus.q     = WIDTH'($urandom);
        chk("busy_after_start", bus.busy, 1);
        edges = 0;
        while (!bus.done && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", edges, ref_lat(qi));
        chk("product", bus.product, exp_p);
        chk("busy_in_done", bus.busy, 1);
        @(negedge clk);
        chk("done_single", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("product_held", bus.product, exp_p);
    endtask

    initial begin
        int edges;
        int done_before;
        n_tests = 0; n_fail = 0; n_req = 0; done_cnt = 0; unstable = 0;
        prev_product = '0; prev_rst = 1'b1;
        bus.start = 1'b0; bus.m = '0; bus.q = '0;
        rst = 1'b1;
        #3;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_product", bus.product, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(4'd15, 4'd15);
        run_op(4'd9,  4'd0);
        run_op(4'd7,  4'd2);

        // Starts during CALC and DONE must be ignored.
        bus.start = 1'b1; bus.m = 4'd3; bus.q = 4'd5; n_req++;
        @(posedge clk);
        @(negedge clk);
        bus.m = 4'd15; bus.q = 4'd15;
        edges = 0;
        while (!bus.done && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        chk("ign_latency", edges, ref_lat(4'd5));
        chk("ign_product", bus.product, 15);
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_busy", bus.busy, 0);
        chk("ign_done", bus.done, 0);
        repeat (8) @(negedge clk);
        chk("ign_product_held", bus.product, 15);
        chk("ign_still_idle", bus.busy, 0);

        // Reset in the middle of the second iteration.
        done_before = done_cnt;
        bus.start = 1'b1; bus.m = 4'd15; bus.q = 4'd15;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_product", bus.product, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt, done_before);
        run_op(4'd2, 4'd3);

        // Random operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Exhaustive sweep at minimum spacing.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(i);
            run_op(pair[7:4], pair[3:0]);
        end

        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, n_req);
        chk("product_stable", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
